instr_fetch_unit: RTL



---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned WORD_INC         = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {instr, pc} pairs for decode.
// Flush wins over push and pop; the head is read straight from storage registers.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one word read at a time to instruction
// memory, and buffers returned instructions for decode. Redirects flush everything.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;

  logic                     pop;
  logic                     push;
  logic                     fifo_push;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [CNT_W-1:0]         count_after;
  logic                     has_space;
  logic [ADDR_W+DATA_W-1:0] fifo_head;

  // A redirect cancels whatever would have been pushed or popped this cycle.
  assign pop         = id_valid & id_ready & ~redirect;
  assign push        = (state_q == REQ) & imem_ack & ~redirect;
  assign fifo_push   = push & (~fifo_full | pop);
  assign count_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(pop);
  assign has_space   = (count_after < CNT_W'(DEPTH));

  fetch_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (pop),
    .flush(redirect),
    .wdata({imem_rdata, fetch_pc_q}),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (redirect || has_space) state_d = REQ;
      end
      REQ: begin
        if (redirect) begin
          state_d = imem_ack ? REQ : DISCARD;
        end else if (imem_ack) begin
          state_d = has_space ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // While discarding, the bus keeps the abandoned address until its ack arrives.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc_q;
    case (state_q)
      REQ: begin
        imem_req = 1'b1;
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = hold_addr_q;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~ADDR_W'(3);
      if ((state_q == REQ) && !imem_ack) hold_addr_d = fetch_pc_q;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(WORD_INC);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= RESET_PC;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  assign id_valid    = ~fifo_empty;
  assign id_instr    = fifo_head[ADDR_W+DATA_W-1:ADDR_W];
  assign id_pc       = fifo_head[ADDR_W-1:0];
  assign id_pc_plus4 = id_pc + ADDR_W'(WORD_INC);

endmodule
